ex_stage_muldiv: RTL and testbench
==================================

# ex_stage_muldiv

Execute stage of the 5-stage RV32IM pipeline, sitting between the ID/EX register and the memory stage. Computes the single-cycle ALU result or runs an iterative 32-cycle multiply/divide unit, raising `stall_o` while busy. Registers everything the memory stage consumes into the EX/MEM pipeline register: control bits, destination register, store data, ALU result, access type and sign flag.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_i  in  1  ID/EX holds a real instruction; 0 means bubble.
- flush_i  in  1  squash the instruction in EX, including an in-flight mul/div.
- op_i  in  7  opcode, passed through.
- alu_ctrl_i  in  4  ALU op select:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR;
  - 5 SLL, 6 SRL, 7 SRA;
  - 8 SLT, 9 SLTU;
  - A pass src_b;
  - others give 0.
- md_i  in  1  M-extension instruction.
- funct3_i  in  3  M op select:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU;
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src_a_i, src_b_i  in  32  forwarded operands; src_b already muxed with the immediate.
- rs2_data_i  in  32  forwarded store data.
- RegWrite_i, MemWrite_i  in  1  control, passed through.
- Result_i  in  2  writeback select, passed through.
- RdD_i  in  5  destination register.
- pc_incr4_i  in  32  PC+4.
- type_i  in  2  memory access size.
- u_i  in  1  unsigned-load flag.
- stall_o  out  1  hold PC, IF/ID and ID/EX.
- op_o, RegWrite_o, MemWrite_o, Result_o, RdD_o, pc_incr4_o, wdata_o, ALU_Result_o, type_o, u_o  out  registered EX/MEM copies; wdata_o comes from rs2_data_i.

## Operation
- ALU path:
  - Shifts use src_b[4:0]; SRA is arithmetic.
  - SLT is a signed compare, SLTU unsigned; the result is 1 or 0.
- Mul/div FSM states: IDLE, BUSY, DONE.
- IDLE:
  - valid_i & md_i & !flush_i latches the operands and funct3 and sets count = 31.
  - It then goes to BUSY, or straight to DONE for special division cases.
- BUSY:
  - One iteration per cycle. Multiply is shift-add on the 64-bit product; divide is restoring on the 32-bit quotient and remainder.
  - Iterations run on magnitudes. The result sign is fixed in DONE.
  - At count == 0 go to DONE; otherwise decrement count.
- DONE:
  - The result is selected: low word (MUL), high word (MULH, MULHSU, MULHU), quotient or remainder.
  - It is captured into ALU_Result_o at this clock edge. The FSM returns to IDLE.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: src_a signed, src_b unsigned.
  - DIV/REM: both signed; the remainder takes the sign of the dividend.
- Special division cases, decided in IDLE, skip BUSY:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- stall_o = (IDLE & valid_i & md_i & !flush_i) | BUSY. It is low in DONE.
- EX/MEM register:
  - When valid_i=0, stall_o=1 or flush_i=1, it loads a bubble: RegWrite_o, MemWrite_o, RdD_o and op_o = 0; other fields don't care.
  - Otherwise it loads the inputs and the result.
- flush_i has priority over everything except rst. It forces the FSM to IDLE in any state and clears stall_o in the same cycle.
- Upstream holds the ID/EX inputs stable while stall_o=1. The block does not depend on this, because the operands are latched.

## Timing
- ALU instruction: 1 cycle in EX. Outputs are valid after the next rising edge.
- Mul/div: stall_o is high for 33 cycles (accept cycle plus 32 BUSY cycles). DONE is the 34th cycle and captures the result. Total occupancy is 34 cycles.
- Special division cases: stall_o is high for 1 cycle. Total occupancy is 2 cycles.
- Back-to-back mul/div: the second one is accepted in the cycle after DONE.
- stall_o is combinational from valid_i, md_i, flush_i and the FSM state.
- Reset values: all registered outputs 0, FSM in IDLE, count 0, stall_o 0.
- Reset mid-operation: the FSM returns to IDLE immediately and partial results are discarded.

## Configuration
- MULDIV_EN defined: the mul/div FSM and datapath are built as above.
- MULDIV_EN undefined:
  - No FSM; stall_o is tied to 0.
  - md_i is ignored, so the instruction takes the ALU path selected by alu_ctrl_i.
  - All instructions are single-cycle.

## Test plan
- ALU sweep: src_a=0x80000000, src_b=1.
  - SRA -> 0xC0000000.
  - SRL -> 0x40000000.
  - SLT -> 1.
  - SLTU -> 0.
  - SUB -> 0x7FFFFFFF.
- MULH with a=0xFFFFFFFE (-2), b=3 -> stall_o high for 33 cycles, then ALU_Result_o=0xFFFFFFFF. With MUL instead -> 0xFFFFFFFA.
- DIV and REM with a=-7 (0xFFFFFFF9), b=2:
  - DIV -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU of the same operands -> 0x7FFFFFFC.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF, 1 stall cycle.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- flush_i pulsed in BUSY cycle 10 -> stall_o low in the same cycle; next EX/MEM has RegWrite_o=0; FSM in IDLE. Then assert rst low mid-BUSY -> all outputs 0 immediately.
- Bubble insertion: ADD issued right after a MUL stall -> exactly 33 bubbles with RegWrite_o=0, the MUL result, then the ADD result on the next cycle.

Source files
------------

// File: rtl/ex_stage_muldiv.sv
// RV32IM execute stage: single-cycle ALU, optional iterative mul/div unit, and the EX/MEM register.
// Define MULDIV_EN to build the 32-iteration multiply/divide FSM; otherwise md_i is ignored.
module ex_stage_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [6:0]  op_i,
    input  logic [3:0]  alu_ctrl_i,
    input  logic        md_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic [31:0] rs2_data_i,
    input  logic        RegWrite_i,
    input  logic        MemWrite_i,
    input  logic [1:0]  Result_i,
    input  logic [4:0]  RdD_i,
    input  logic [31:0] pc_incr4_i,
    input  logic [1:0]  type_i,
    input  logic        u_i,
    output logic        stall_o,
    output logic [6:0]  op_o,
    output logic        RegWrite_o,
    output logic        MemWrite_o,
    output logic [1:0]  Result_o,
    output logic [4:0]  RdD_o,
    output logic [31:0] pc_incr4_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ALU_Result_o,
    output logic [1:0]  type_o,
    output logic        u_o
);
    localparam int DATA_W = 32;

    logic signed [DATA_W-1:0] w_src_a_s;
    logic signed [DATA_W-1:0] w_src_b_s;
    logic        [DATA_W-1:0] w_alu;
    logic        [DATA_W-1:0] w_result;
    logic                     w_bubble;

    assign w_src_a_s = src_a_i;
    assign w_src_b_s = src_b_i;

    always_comb begin
        w_alu = '0;
        case (alu_ctrl_i)
            4'h0:    w_alu = src_a_i + src_b_i;
            4'h1:    w_alu = src_a_i - src_b_i;
            4'h2:    w_alu = src_a_i & src_b_i;
            4'h3:    w_alu = src_a_i | src_b_i;
            4'h4:    w_alu = src_a_i ^ src_b_i;
            4'h5:    w_alu = src_a_i << src_b_i[4:0];
            4'h6:    w_alu = src_a_i >> src_b_i[4:0];
            4'h7:    w_alu = w_src_a_s >>> src_b_i[4:0];
            4'h8:    w_alu = {31'd0, w_src_a_s < w_src_b_s};
            4'h9:    w_alu = {31'd0, src_a_i < src_b_i};
            4'hA:    w_alu = src_b_i;
            default: w_alu = '0;
        endcase
    end

`ifdef MULDIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_count;
    logic [2:0]  r_f3;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_mag_a;
    logic [31:0] r_mag_b;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [63:0] r_prod;
    logic        w_accept;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic        w_div0;
    logic        w_ovf;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic [63:0] w_prod_s;
    logic [31:0] w_md_res;

    function automatic logic [31:0] neg32(input logic n, input logic [31:0] v);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic n, input logic [63:0] v);
        return n ? (~v + 64'd1) : v;
    endfunction

    assign w_accept   = (r_state == S_IDLE) & valid_i & md_i & ~flush_i;
    assign w_a_signed = (funct3_i == 3'd1) | (funct3_i == 3'd2) | (funct3_i == 3'd4) | (funct3_i == 3'd6);
    assign w_b_signed = (funct3_i == 3'd1) | (funct3_i == 3'd4) | (funct3_i == 3'd6);
    assign w_neg_a    = w_a_signed & src_a_i[31];
    assign w_neg_b    = w_b_signed & src_b_i[31];
    assign w_mag_a    = neg32(w_neg_a, src_a_i);
    assign w_mag_b    = neg32(w_neg_b, src_b_i);
    assign w_div0     = funct3_i[2] & (src_b_i == 32'd0);
    assign w_ovf      = funct3_i[2] & ~funct3_i[0] & (src_a_i == 32'h8000_0000) & (src_b_i == 32'hFFFF_FFFF);
    assign stall_o    = w_accept | ((r_state == S_BUSY) & ~flush_i);

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_state_nxt = (w_div0 | w_ovf) ? S_DONE : S_BUSY;
                S_BUSY:  if (r_count == 5'd0) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_count <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_count <= 5'd31;
            else if ((r_state == S_BUSY) && !flush_i && (r_count != 5'd0))
                r_count <= r_count - 5'd1;
        end
    end

    // Iteration datapath: shift-add multiply and restoring divide, both on magnitudes
    assign w_mul_sum   = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mag_a} : 33'd0);
    assign w_div_shift = {r_rem, r_quo[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_f3    <= funct3_i;
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_prod  <= {32'd0, w_mag_b};
            r_quo   <= w_mag_a;
            r_rem   <= 32'd0;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            // Special cases preload the final values with no sign fix-up
            if (w_div0) begin
                r_quo   <= 32'hFFFF_FFFF;
                r_rem   <= src_a_i;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else if (w_ovf) begin
                r_quo   <= 32'h8000_0000;
                r_rem   <= 32'd0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end
        end else if (r_state == S_BUSY) begin
            if (r_f3[2]) begin
                if (!w_div_diff[32]) begin
                    r_rem <= w_div_diff[31:0];
                    r_quo <= {r_quo[30:0], 1'b1};
                end else begin
                    r_rem <= w_div_shift[31:0];
                    r_quo <= {r_quo[30:0], 1'b0};
                end
            end else begin
                r_prod <= {w_mul_sum, r_prod[31:1]};
            end
        end
    end

    assign w_prod_s = neg64(r_neg_q, r_prod);

    always_comb begin
        w_md_res = '0;
        case (r_f3)
            3'd0:              w_md_res = w_prod_s[31:0];
            3'd1, 3'd2, 3'd3:  w_md_res = w_prod_s[63:32];
            3'd4, 3'd5:        w_md_res = neg32(r_neg_q, r_quo);
            default:           w_md_res = neg32(r_neg_r, r_rem);
        endcase
    end

    assign w_result = (r_state == S_DONE) ? w_md_res : w_alu;
`else
    logic w_unused_md;
    assign w_unused_md = ^{md_i, funct3_i};
    assign stall_o     = 1'b0;
    assign w_result    = w_alu;
`endif

    // EX/MEM pipeline register
    assign w_bubble = ~valid_i | stall_o | flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_o         <= '0;
            RegWrite_o   <= 1'b0;
            MemWrite_o   <= 1'b0;
            Result_o     <= '0;
            RdD_o        <= '0;
            pc_incr4_o   <= '0;
            wdata_o      <= '0;
            ALU_Result_o <= '0;
            type_o       <= '0;
            u_o          <= 1'b0;
        end else begin
            op_o         <= w_bubble ? 7'd0 : op_i;
            RegWrite_o   <= ~w_bubble & RegWrite_i;
            MemWrite_o   <= ~w_bubble & MemWrite_i;
            RdD_o        <= w_bubble ? 5'd0 : RdD_i;
            Result_o     <= Result_i;
            pc_incr4_o   <= pc_incr4_i;
            wdata_o      <= rs2_data_i;
            ALU_Result_o <= w_result;
            type_o       <= type_i;
            u_o          <= u_i;
        end
    end
endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Scoreboard bench for ex_stage_muldiv: expected EX/MEM contents are queued at issue and
// popped by a negedge monitor whenever RegWrite_o marks a real instruction leaving EX.
module tb_ex_stage_muldiv;
`ifdef MULDIV_EN
    localparam bit MD_BUILT = 1'b1;
`else
    localparam bit MD_BUILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, flush_i, md_i, RegWrite_i, MemWrite_i, u_i;
    logic [6:0]  op_i;
    logic [3:0]  alu_ctrl_i;
    logic [2:0]  funct3_i;
    logic [31:0] src_a_i, src_b_i, rs2_data_i, pc_incr4_i;
    logic [1:0]  Result_i, type_i;
    logic [4:0]  RdD_i;
    logic        stall_o, RegWrite_o, MemWrite_o, u_o;
    logic [6:0]  op_o;
    logic [1:0]  Result_o, type_o;
    logic [4:0]  RdD_o;
    logic [31:0] pc_incr4_o, wdata_o, ALU_Result_o;

    always #5 clk = ~clk;

    ex_stage_muldiv dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .op_i(op_i),
        .alu_ctrl_i(alu_ctrl_i), .md_i(md_i), .funct3_i(funct3_i), .src_a_i(src_a_i),
        .src_b_i(src_b_i), .rs2_data_i(rs2_data_i), .RegWrite_i(RegWrite_i),
        .MemWrite_i(MemWrite_i), .Result_i(Result_i), .RdD_i(RdD_i), .pc_incr4_i(pc_incr4_i),
        .type_i(type_i), .u_i(u_i), .stall_o(stall_o), .op_o(op_o), .RegWrite_o(RegWrite_o),
        .MemWrite_o(MemWrite_o), .Result_o(Result_o), .RdD_o(RdD_o), .pc_incr4_o(pc_incr4_o),
        .wdata_o(wdata_o), .ALU_Result_o(ALU_Result_o), .type_o(type_o), .u_o(u_o)
    );

    typedef struct {
        logic [31:0] res;
        logic [6:0]  op;
        logic        mw;
        logic [1:0]  rsel;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] wd;
        logic [1:0]  ty;
        logic        u;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    exp_t e_tmp;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_issued = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << b[4:0];
            4'h6: return a >> b[4:0];
            4'h7: begin t = 64'(sa >>> b[4:0]); return t[31:0]; end
            4'h8: return (sa < sb) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
            4'hA: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] c, input logic md, input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] b);
        return (MD_BUILT && md) ? ref_md(f3, a, b) : ref_alu(c, a, b);
    endfunction

    function automatic int ref_stalls(input logic md, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!(MD_BUILT && md)) return 0;
        if (f3[2] && (b == 0)) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic drive(input logic [3:0] c, input logic md, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, output exp_t e);
        valid_i = 1'b1; flush_i = 1'b0; alu_ctrl_i = c; md_i = md; funct3_i = f3;
        src_a_i = a; src_b_i = b;
        rs2_data_i = $urandom; pc_incr4_i = $urandom; op_i = 7'($urandom);
        MemWrite_i = 1'($urandom); Result_i = 2'($urandom); type_i = 2'($urandom); u_i = 1'($urandom);
        RegWrite_i = 1'b1;
        RdD_i = 5'(1 + (n_issued % 31));
        n_issued++;
        e.res = ref_result(c, md, f3, a, b);
        e.op = op_i; e.mw = MemWrite_i; e.rsel = Result_i; e.rd = RdD_i;
        e.pc = pc_incr4_i; e.wd = rs2_data_i; e.ty = type_i; e.u = u_i;
    endtask

    task automatic issue(input logic [3:0] c, input logic md, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int stalls;
        drive(c, md, f3, a, b, e);
        q.push_back(e);
        stalls = 0;
        #1;
        while (stall_o && stalls < 40) begin
            stalls++;
            @(posedge clk); #1;
        end
        chk("stall_cycles", 64'(stalls), 64'(ref_stalls(md, f3, a, b)));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every cycle leaving EX is either a queued instruction or a clean bubble
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (RegWrite_o) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_output: got RdD_o=%0d result=0x%0h, expected a bubble", RdD_o, ALU_Result_o);
                end else begin
                    mon_e = q.pop_front();
                    chk("alu_result", 64'(ALU_Result_o), 64'(mon_e.res));
                    chk("rd_op_mw", {RdD_o, op_o, MemWrite_o}, {mon_e.rd, mon_e.op, mon_e.mw});
                    chk("pc_wdata", {pc_incr4_o, wdata_o}, {mon_e.pc, mon_e.wd});
                    chk("sideband", {Result_o, type_o, u_o}, {mon_e.rsel, mon_e.ty, mon_e.u});
                end
            end else begin
                chk("bubble_fields", {MemWrite_o, RdD_o, op_o}, 64'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_i = 0; flush_i = 0; md_i = 0; RegWrite_i = 0; MemWrite_i = 0; u_i = 0;
        op_i = 0; alu_ctrl_i = 0; funct3_i = 0; src_a_i = 0; src_b_i = 0; rs2_data_i = 0;
        pc_incr4_i = 0; Result_i = 0; type_i = 0; RdD_i = 0;
        #2 rst = 1'b0;
        #2;
        chk("reset_ctrl", {stall_o, op_o, RegWrite_o, MemWrite_o, Result_o, RdD_o, type_o, u_o}, 64'd0);
        chk("reset_data", {pc_incr4_o, wdata_o}, 64'd0);
        chk("reset_alu", 64'(ALU_Result_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // ALU sweep on the sign-boundary operand
        issue(4'h7, 0, 0, 32'h8000_0000, 32'd1);
        issue(4'h6, 0, 0, 32'h8000_0000, 32'd1);
        issue(4'h8, 0, 0, 32'h8000_0000, 32'd1);
        issue(4'h9, 0, 0, 32'h8000_0000, 32'd1);
        issue(4'h1, 0, 0, 32'h8000_0000, 32'd1);

        // Multiply/divide directed cases, back to back
        issue(4'h0, 1, 3'd1, 32'hFFFF_FFFE, 32'd3);
        issue(4'h0, 1, 3'd0, 32'hFFFF_FFFE, 32'd3);
        issue(4'h0, 1, 3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(4'h0, 1, 3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(4'h0, 1, 3'd5, 32'hFFFF_FFF9, 32'd2);
        issue(4'h0, 1, 3'd5, 32'd5, 32'd0);
        issue(4'h0, 1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'h0, 1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'h0, 1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // MUL immediately followed by ADD
        issue(4'h0, 1, 3'd0, 32'd1234, 32'd5678);
        issue(4'h0, 0, 3'd0, 32'd100, 32'd23);

        // Flushed ALU instruction must leave as a bubble
        drive(4'h0, 0, 0, 32'd1, 32'd2, e_tmp);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        chk("flush_alu_regwrite", 64'(RegWrite_o), 64'd0);
        @(posedge clk); #1;

`ifdef MULDIV_EN
        // Flush in BUSY cycle 10
        drive(4'h0, 1, 3'd0, 32'h1234, 32'h55, e_tmp);
        #1 chk("accept_stall", 64'(stall_o), 64'd1);
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        #1 chk("flush_stall_low", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        #1 chk("idle_after_flush", 64'(stall_o), 64'd0);
        @(negedge clk);
        chk("flush_md_regwrite", 64'(RegWrite_o), 64'd0);
        @(posedge clk); #1;
        issue(4'h0, 1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        // Reset mid-BUSY
        drive(4'h0, 1, 3'd1, 32'd5, 32'd3, e_tmp);
        repeat (5) @(posedge clk);
        #1;
`else
        issue(4'h0, 0, 0, 32'd5, 32'd3);
        @(negedge clk); #1;
`endif
        rst = 1'b0; valid_i = 1'b0;
        #1;
        chk("midrun_reset_ctrl", {stall_o, op_o, RegWrite_o, MemWrite_o, Result_o, RdD_o, type_o, u_o}, 64'd0);
        chk("midrun_reset_data", {pc_incr4_o, wdata_o}, 64'd0);
        chk("midrun_reset_alu", 64'(ALU_Result_o), 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        issue(4'h0, 1, 3'd0, 32'd7, 32'd6);
        issue(4'h4, 0, 0, 32'hA5A5_0F0F, 32'h0F0F_A5A5);

        // Randomized mix with occasional bubbles
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            a = pick();
            b = pick();
            issue(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), a, b);
            if ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                @(posedge clk); #1;
            end
        end

        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
